// File: rtl/async_fifo_pkg.sv
// Shared constants and helpers for the async_fifo block and its read-side stream consumer.
package async_fifo_pkg;

  localparam int unsigned BUF_DEPTH          = 3;
  localparam int unsigned PTR_W              = 2;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_CNT_WIDTH  = 16;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   sum_t;

  // Circular pointer increment, wrapping BUF_DEPTH-1 -> 0.
  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // True while buffered plus in-flight words leave a free slot.
  function automatic logic has_room(ptr_t occ, logic inflight);
    return (sum_t'(occ) + sum_t'(inflight)) < sum_t'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/async_fifo_rd_stream_if.sv
// FIFO pop interface plus valid/ready stream output of the read-side consumer.
interface async_fifo_rd_stream_if
  import async_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic                  fifo_rd_en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_rd_data,
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_rd_data,
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/rd_prefetch_buf.sv
// Three-entry circular prefetch buffer with head/tail pointers and occupancy count.
module rd_prefetch_buf
  import async_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output ptr_t                  occ_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  ptr_t occ_q, occ_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (clr_i) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (wr_en_i) tail_d = ptr_inc(tail_q);
      if (rd_en_i) head_d = ptr_inc(head_q);
      // Simultaneous write and read leaves occupancy unchanged.
      case ({wr_en_i, rd_en_i})
        2'b10:   occ_d = occ_q + ptr_t'(1);
        2'b01:   occ_d = occ_q - ptr_t'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      if (wr_en_i && !clr_i) begin
        mem_q[tail_q] <= wr_data_i;
      end
    end
  end

  assign occ_o     = occ_q;
  assign valid_o   = (occ_q != '0);
  assign rd_data_o = mem_q[head_q];

endmodule

// File: rtl/async_fifo_rd_stream.sv
// Read-domain consumer: pops async_fifo words through a prefetch buffer onto a valid/ready
// stream and counts delivered words.
module async_fifo_rd_stream
  import async_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic                 flush,
  async_fifo_rd_stream_if.master bus,
  output logic [CNT_WIDTH-1:0] pop_count
);

  logic                 inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] pop_count_q, pop_count_d;
  ptr_t                 occ;
  logic                 buf_valid;
  logic                 rd_en;
  logic                 capture;
  logic                 pop;

  // Issue depends only on registered state and FIFO/flush/reset, never on m_ready.
  always_comb begin
    rd_en       = !rd_rst && !flush && !bus.fifo_empty && has_room(occ, inflight_q);
    capture     = inflight_q && !flush;
    pop         = buf_valid && bus.m_ready && !flush;
    inflight_d  = rd_en;
    pop_count_d = pop_count_q;
    if (pop) pop_count_d = pop_count_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      inflight_q  <= 1'b0;
      pop_count_q <= '0;
    end else begin
      inflight_q  <= inflight_d;
      pop_count_q <= pop_count_d;
    end
  end

  rd_prefetch_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk_i     (rd_clk),
    .rst_i     (rd_rst),
    .clr_i     (flush),
    .wr_en_i   (capture),
    .wr_data_i (bus.fifo_rd_data),
    .rd_en_i   (pop),
    .occ_o     (occ),
    .valid_o   (buf_valid),
    .rd_data_o (bus.m_data)
  );

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = buf_valid;
  assign pop_count      = pop_count_q;

endmodule

// File: doc/async_fifo_rd_stream.md
# async_fifo_rd_stream

Read-side consumer for the `async_fifo` block, running entirely in the read clock domain. It pulls words from the FIFO's `rd_en`/`empty` interface and presents them on a valid/ready streaming output. A 3-entry prefetch buffer hides the FIFO's one-cycle RAM read latency, so it sustains one word per clock. It also keeps a wrapping count of delivered words.

## Interface
- `DATA_WIDTH`, 8, width of FIFO word and stream data.
- `CNT_WIDTH`, 16, width of delivered-word counter.
- `rd_clk  input  1  read-domain clock; all logic on rising edge`
- `rd_rst  input  1  synchronous, active-high reset`
- `flush  input  1  synchronous discard of all buffered and in-flight words`
- `fifo_rd_en  output  1  pop request to async_fifo rd_en`
- `fifo_empty  input  1  async_fifo empty flag`
- `fifo_rd_data  input  DATA_WIDTH  async_fifo rd_data, valid the cycle after fifo_rd_en`
- `m_valid  output  1  stream word available`
- `m_data  output  DATA_WIDTH  stream word`
- `m_ready  input  1  downstream accepts word`
- `pop_count  output  CNT_WIDTH  words delivered since reset, wraps`

## Operation
- State:
  - `occ` (0..3): buffered entries.
  - `inflight` (0..1): read issued last cycle.
  - circular buffer of 3 × DATA_WIDTH with 2-bit head/tail pointers, wrapping 2→0.
- Issue rule:
  - `fifo_rd_en = !rd_rst && !flush && !fifo_empty && (occ + inflight < 3)`.
  - Depends only on registers and `fifo_empty`/`flush`/`rd_rst`; there is no combinational path from `m_ready`.
- Capture: when `inflight`=1, `fifo_rd_data` is written at tail and tail advances. The invariant `occ + inflight ≤ 3` guarantees the buffer never overflows.
- Output: `m_valid = (occ != 0)`, `m_data = buf[head]`.
  - Handshake completes when `m_valid && m_ready`; head then advances and `pop_count` increments modulo 2^CNT_WIDTH.
- Simultaneous capture and handshake in one cycle: `occ` is unchanged and both pointers advance.
- `m_data` is held stable while `m_valid && !m_ready`. It is don't-care-stable when `m_valid`=0 (it holds the last buffer slot).
- Flush: `occ`, `inflight` and both pointers are set to 0. Data arriving in the cycle after flush from a read issued before flush is discarded. `fifo_rd_en` is 0 during the flush cycle. `pop_count` is not cleared. A handshake coinciding with flush does not count.
- Reset:
  - Outputs: `m_valid`=0, `m_data`=0, `fifo_rd_en`=0, `pop_count`=0.
  - Internal: buffer cleared, `inflight`=0.
  - A word popped from the FIFO in the cycle before reset is lost. This is accepted behaviour, since both FIFO domains are reset together.

## Timing
- Latency: FIFO non-empty at cycle N with buffer idle → `fifo_rd_en`=1 at N → `m_valid`=1 at N+2 with that word.
- Steady state with `m_ready`=1 and FIFO never empty: one word per cycle after the 2-cycle fill.
- Backpressure: with `m_ready`=0, at most 3 words are buffered and `fifo_rd_en` then stays 0. When `m_ready` rises, words drain at 1 per cycle and issue resumes in the same cycle `occ` drops.
- `fifo_empty` rising: issue stops the same cycle; no read is ever issued while `fifo_empty`=1.

## Structure
- Shared `async_fifo_pkg` holds:
  - `BUF_DEPTH = 3`
  - pointer width `PTR_W = 2`
  - the default `DATA_WIDTH`/`CNT_WIDTH` values used by `async_fifo` and this block.
- One sub-module, `rd_prefetch_buf`, holds the 3-entry storage with head/tail/occ logic. The top module keeps issue control, `inflight`, flush and `pop_count`.

## Test plan
- Reset mid-stream: assert `rd_rst` for 1 cycle with `occ`=2 → next cycle `m_valid`=0, `m_data`=0, `pop_count`=0, `fifo_rd_en`=0.
- Streaming: FIFO holds 0x01..0x10, `m_ready`=1 → `m_data` 0x01..0x10 on 16 consecutive cycles starting 2 cycles after first `fifo_rd_en`, `pop_count`=16.
- Backpressure: `m_ready`=0, FIFO holds 8 words → exactly 3 `fifo_rd_en` pulses and `m_data`=first word held stable. Then `m_ready`=1 → all 8 words delivered in order with no gaps.
- Empty boundary: FIFO gives 1 word, then `fifo_empty`=1 → one `fifo_rd_en` pulse, one handshake, and `fifo_rd_en` never asserted while empty.
- Flush with in-flight read: `flush` in the cycle after `fifo_rd_en` with `occ`=2 → `m_valid`=0 next cycle, the arriving word is dropped, and the next delivered word is the following FIFO word. `pop_count` is unchanged by the flush.
- Counter wrap: `CNT_WIDTH`=4, 17 handshakes → `pop_count`=1.
